fir_coef_bank_ctrl: RTL and testbench
=====================================

// Module: fir_coef_bank_ctrl
// PURPOSE
//  Runtime coefficient loader/scheduler for the TAPS-wide FIR datapath.
//  - Accepts a serial valid/ready stream of 16-bit weights into a shadow bank.
//  - Validates the frame length.
//  - Commits shadow to the active bank only on a sample boundary, so no output mixes old and new weights.
//  - The active bank drives the FIR in_weights array directly.
// PARAMETERS
//  TAPS    401  filter length; size of active and shadow banks
//  COEF_W  16   coefficient width (must match FIR weight width)
// PORTS
//  clk           in   1             system clock, rising edge
//  rst           in   1             asynchronous reset, active-low (0 = reset)
//  cfg_valid     in   1             cfg_data holds a coefficient beat
//  cfg_ready     out  1             loader can accept a beat
//  cfg_data      in   COEF_W        coefficient, two's complement
//  cfg_last      in   1             marks final beat of a coefficient frame
//  cfg_abort     in   1             discard any load in progress
//  sample_tick   in   1             FIR accepted a sample this cycle (its in_valid & in_ready)
//  coef_out      out  COEF_W x TAPS active bank, [0:TAPS-1], to FIR in_weights
//  busy          out  1             load or pending commit in progress
//  coef_updated  out  1             1-cycle pulse: active bank changed
//  load_err      out  1             1-cycle pulse: malformed frame discarded
//  coef_version  out  8             count of commits since reset
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE, wr_idx=0, coef_out all 0, shadow all 0.
//   - coef_updated=0, load_err=0, coef_version=0.
//  N_LOAD = TAPS (see CONFIGURATION). FSM states: IDLE, LOAD, PENDING, ERR.
//  cfg_ready = 1 in IDLE and LOAD, 0 in PENDING and ERR (decoded from state).
//  busy = (state != IDLE).
//  Beat = cfg_valid & cfg_ready. On each beat: shadow[wr_idx] <= cfg_data, then:
//   - cfg_last & wr_idx==N_LOAD-1 -> PENDING, wr_idx <= 0.
//   - cfg_last & wr_idx< N_LOAD-1 -> ERR (frame short).
//   - !cfg_last & wr_idx==N_LOAD-1 -> ERR (frame long).
//   - otherwise wr_idx++. First beat moves IDLE -> LOAD.
//  PENDING:
//   - Waits for sample_tick. On that edge: coef_out <= shadow (whole bank, one edge), coef_version++ (wraps 255->0).
//   - Next cycle: coef_updated=1 and state=IDLE.
//   - A sample_tick in the same cycle as the last beat does NOT commit; the first tick strictly afterwards does.
//  ERR:
//   - Lasts one cycle with load_err=1, then -> IDLE, wr_idx=0.
//   - Shadow contents are don't-care. coef_out is never disturbed.
//  cfg_abort (LOAD or PENDING):
//   - -> IDLE and wr_idx=0. No commit, no load_err.
//   - Same-cycle beat is dropped. Abort wins over sample_tick.
//   - Ignored in IDLE and ERR.
//  sample_tick outside PENDING: ignored.
//  Reset mid-load or mid-pending: everything returns to reset values, including coef_out = 0.
//  coef_out is registered only. FIR sees the new bank on the cycle after the commit edge.
// CONFIGURATION
//  FIR_COEF_SYMMETRIC_EN:
//   - Defined: linear-phase load. N_LOAD=(TAPS+1)/2, shadow depth N_LOAD.
//   - Commit writes coef_out[k] and coef_out[TAPS-1-k] from shadow[k].
//   - Frame-length checks use N_LOAD.
//  Undefined: N_LOAD=TAPS, coef_out[k] <= shadow[k].
// TESTING (bench TAPS=5 unless noted)
//  1. Reset, no traffic:
//     - coef_out all 0, cfg_ready=1, busy=0, coef_version=0.
//  2. Normal load and commit:
//     - Load 1,2,3,4,5 (last on 5), idle 3 cycles: coef_out unchanged, busy=1, cfg_ready=0.
//     - Then tick: coef_out={1,2,3,4,5}, coef_updated pulses once, coef_version=1.
//  3. Short frame:
//     - 3 beats with last on the third -> load_err 1-cycle pulse, coef_out unchanged, state IDLE.
//     - A following valid 5-beat frame commits normally.
//  4. Long frame:
//     - 5 beats without last -> load_err. The 6th beat is accepted as the first beat of a new frame.
//  5. Abort and tick priority:
//     - Full frame, then cfg_abort and sample_tick in the same cycle -> no commit, coef_version unchanged.
//     - Also assert rst=0 mid-load: all outputs return to reset values within the same cycle.
//  6. FIR_COEF_SYMMETRIC_EN, TAPS=5:
//     - Load 7,8,9 -> coef_out={7,8,9,8,7} after tick.
//     - 256 commits -> coef_version wraps to 0.

Source files
------------

// File: rtl/fir_coef_bank_ctrl.sv
// fir_coef_bank_ctrl: serial coefficient loader into a shadow bank, committed to the FIR on a sample boundary.
// Optional FIR_COEF_SYMMETRIC_EN: load (TAPS+1)/2 weights and mirror them across the bank on commit.
module fir_coef_bank_ctrl #(
    parameter int unsigned TAPS   = 401,
    parameter int unsigned COEF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [COEF_W-1:0] cfg_data,
    input  logic              cfg_last,
    input  logic              cfg_abort,
    input  logic              sample_tick,
    output logic [COEF_W-1:0] coef_out [0:TAPS-1],
    output logic              busy,
    output logic              coef_updated,
    output logic              load_err,
    output logic [7:0]        coef_version
);

`ifdef FIR_COEF_SYMMETRIC_EN
    localparam int unsigned N_LOAD = (TAPS + 1) / 2;
`else
    localparam int unsigned N_LOAD = TAPS;
`endif
    localparam int unsigned      IDX_W    = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LOAD - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PENDING, ERR} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [COEF_W-1:0] r_shadow [0:N_LOAD-1];
    logic              w_abort;
    logic              w_beat;
    logic              w_at_end;
    logic              w_commit;

    always_comb begin
        w_next_state = r_state;
        cfg_ready    = (r_state == IDLE) || (r_state == LOAD);
        busy         = (r_state != IDLE);
        load_err     = (r_state == ERR);
        w_abort      = cfg_abort && ((r_state == LOAD) || (r_state == PENDING));
        w_beat       = cfg_valid && cfg_ready && !w_abort;
        w_at_end     = (r_wr_idx == LAST_IDX);
        // abort takes priority over a coincident sample tick
        w_commit     = (r_state == PENDING) && sample_tick && !cfg_abort;
        case (r_state)
            IDLE, LOAD: begin
                if (w_abort) begin
                    w_next_state = IDLE;
                end else if (w_beat) begin
                    if (cfg_last) begin
                        w_next_state = w_at_end ? PENDING : ERR;
                    end else begin
                        w_next_state = w_at_end ? ERR : LOAD;
                    end
                end
            end
            PENDING: begin
                if (w_abort || w_commit) begin
                    w_next_state = IDLE;
                end
            end
            ERR:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_idx     <= '0;
            coef_updated <= 1'b0;
            coef_version <= '0;
            for (int unsigned k = 0; k < N_LOAD; k++) begin
                r_shadow[k] <= '0;
            end
            for (int unsigned k = 0; k < TAPS; k++) begin
                coef_out[k] <= '0;
            end
        end else begin
            coef_updated <= w_commit;
            if (w_abort) begin
                r_wr_idx <= '0;
            end else if (w_beat) begin
                r_shadow[r_wr_idx] <= cfg_data;
                r_wr_idx           <= (w_next_state == LOAD) ? r_wr_idx + 1'b1 : '0;
            end
            if (w_commit) begin
                coef_version <= coef_version + 8'd1;
`ifdef FIR_COEF_SYMMETRIC_EN
                // centre tap is written twice with the same value when TAPS is odd
                for (int unsigned k = 0; k < N_LOAD; k++) begin
                    coef_out[k]          <= r_shadow[k];
                    coef_out[TAPS-1-k]   <= r_shadow[k];
                end
`else
                for (int unsigned k = 0; k < TAPS; k++) begin
                    coef_out[k] <= r_shadow[k];
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Testbench for fir_coef_bank_ctrl (TAPS=5): vector table, directed corner cases, randomized frames vs. model.
module tb_fir_coef_bank_ctrl;
    localparam int unsigned TAPS   = 5;
    localparam int unsigned COEF_W = 16;
`ifdef FIR_COEF_SYMMETRIC_EN
    localparam int N_LOAD = (TAPS + 1) / 2;
`else
    localparam int N_LOAD = TAPS;
`endif

    typedef logic [COEF_W-1:0] coef_t;

    typedef struct {
        logic       v;
        coef_t      d;
        logic       last;
        logic       abort;
        logic       tick;
        logic       e_ready;
        logic       e_busy;
        logic       e_upd;
        logic       e_err;
        logic [7:0] e_ver;
        logic       e_committed;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_last = 1'b0;
    logic       cfg_abort = 1'b0;
    logic       sample_tick = 1'b0;
    coef_t      cfg_data = '0;
    logic       cfg_ready;
    logic       busy;
    logic       coef_updated;
    logic       load_err;
    logic [7:0] coef_version;
    coef_t      coef_out [0:TAPS-1];

    int         n_vec = 0;
    int         n_err = 0;
    int         upd_seen = 0;
    int         err_seen = 0;
    int         exp_upd = 0;
    int         exp_errp = 0;
    logic [7:0] exp_ver = '0;
    coef_t      exp_bank [TAPS];

    always #5 clk = ~clk;

    fir_coef_bank_ctrl #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .cfg_last     (cfg_last),
        .cfg_abort    (cfg_abort),
        .sample_tick  (sample_tick),
        .coef_out     (coef_out),
        .busy         (busy),
        .coef_updated (coef_updated),
        .load_err     (load_err),
        .coef_version (coef_version)
    );

    always @(negedge clk) begin
        if (coef_updated === 1'b1) upd_seen++;
        if (load_err === 1'b1) err_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bank(input string name);
        int bad = -1;
        for (int k = 0; k < TAPS; k++) begin
            if (coef_out[k] !== exp_bank[k] && bad < 0) bad = k;
        end
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: coef_out[%0d] got %0h, expected %0h", name, bad, coef_out[bad], exp_bank[bad]);
        end
    endtask

    // Tap k of the bank a committed frame produces (mirrored halves when symmetric).
    function automatic coef_t tap_of(input coef_t f [$], input int k);
`ifdef FIR_COEF_SYMMETRIC_EN
        return f[(k < N_LOAD) ? k : (TAPS - 1 - k)];
`else
        return f[k];
`endif
    endfunction

    task automatic model_commit(input coef_t f [$]);
        for (int k = 0; k < TAPS; k++) exp_bank[k] = tap_of(f, k);
        exp_ver = exp_ver + 8'd1;
        exp_upd++;
    endtask

    task automatic send_beat(input coef_t d, input logic last, input logic tick);
        int n = 0;
        cfg_valid   = 1'b1;
        cfg_data    = d;
        cfg_last    = last;
        sample_tick = tick;
        while (cfg_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("ready_timeout", cfg_ready, 1);
        step();
        cfg_valid   = 1'b0;
        cfg_last    = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic send_frame(input coef_t f [$], input bit with_last, input bit rnd);
        for (int i = 0; i < f.size(); i++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    sample_tick = 1'($urandom_range(0, 1));
                    step();
                    sample_tick = 1'b0;
                end
            end
            send_beat(f[i], with_last && (i == f.size() - 1), rnd ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    task automatic tick_commit(input coef_t f [$]);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        model_commit(f);
    endtask

    task automatic rand_frame(output coef_t f [$], input int len);
        f.delete();
        for (int i = 0; i < len; i++) f.push_back(coef_t'($urandom));
    endtask

    function automatic vec_t mk(input logic v, input coef_t d, input logic last, input logic abort,
                                input logic tick, input logic rdy, input logic bsy, input logic upd,
                                input logic err, input logic [7:0] ver, input logic com);
        vec_t r;
        r.v = v; r.d = d; r.last = last; r.abort = abort; r.tick = tick;
        r.e_ready = rdy; r.e_busy = bsy; r.e_upd = upd; r.e_err = err; r.e_ver = ver; r.e_committed = com;
        return r;
    endfunction

    initial begin
        vec_t  tbl [$];
        coef_t ramp [$];
        coef_t f [$];
        coef_t g [$];
        int    s_len;

        for (int k = 0; k < TAPS; k++) exp_bank[k] = '0;
        for (int i = 0; i < N_LOAD; i++) ramp.push_back(coef_t'(i + 1));
        s_len = N_LOAD - 2;

        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < N_LOAD; i++)
            tbl.push_back(mk(1, coef_t'(i + 1), i == N_LOAD - 1, 0, i == N_LOAD - 1,
                             i != N_LOAD - 1, 1, 0, 0, 0, 0));
        repeat (3) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
        for (int i = 0; i < s_len; i++)
            tbl.push_back(mk(1, coef_t'(100 + i), i == s_len - 1, 0, 0,
                             i != s_len - 1, 1, 0, i == s_len - 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));

        // reset, then no traffic
        repeat (2) step();
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ver", coef_version, 0);
        chk_bank("rst_bank");
        rst = 1'b1;
        step();

        foreach (tbl[i]) begin
            cfg_valid = tbl[i].v; cfg_data = tbl[i].d; cfg_last = tbl[i].last;
            cfg_abort = tbl[i].abort; sample_tick = tbl[i].tick;
            step();
            for (int k = 0; k < TAPS; k++) exp_bank[k] = tbl[i].e_committed ? tap_of(ramp, k) : coef_t'(0);
            chk($sformatf("tbl%0d_ready", i), cfg_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_upd", i), coef_updated, tbl[i].e_upd);
            chk($sformatf("tbl%0d_err", i), load_err, tbl[i].e_err);
            chk($sformatf("tbl%0d_ver", i), coef_version, tbl[i].e_ver);
            chk_bank($sformatf("tbl%0d_bank", i));
        end
        cfg_valid = 0; cfg_last = 0; cfg_abort = 0; sample_tick = 0;
        exp_ver = 8'd1; exp_upd = 1; exp_errp = 1;

        // long frame: the extra beat starts a new frame once ERR has passed
        rand_frame(f, N_LOAD);
        send_frame(f, 0, 0);
        chk("long_err", load_err, 1);
        chk("long_ready", cfg_ready, 0);
        exp_errp++;
        rand_frame(g, N_LOAD);
        send_frame(g, 1, 0);
        chk("long_pending", busy, 1);
        tick_commit(g);
        chk("long_upd", coef_updated, 1);
        chk_bank("long_bank");
        chk("long_ver", coef_version, exp_ver);

        // abort together with tick in PENDING: no commit
        rand_frame(f, N_LOAD);
        send_frame(f, 1, 0);
        cfg_abort = 1'b1; sample_tick = 1'b1;
        step();
        cfg_abort = 1'b0; sample_tick = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ver", coef_version, exp_ver);
        step();
        chk("abort_upd", coef_updated, 0);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("idle_tick_ver", coef_version, exp_ver);
        chk_bank("abort_bank");

`ifdef FIR_COEF_SYMMETRIC_EN
        f.delete(); f.push_back(16'd7); f.push_back(16'd8); f.push_back(16'd9);
        send_frame(f, 1, 0);
        tick_commit(f);
        g.delete(); g.push_back(16'd7); g.push_back(16'd8); g.push_back(16'd9); g.push_back(16'd8); g.push_back(16'd7);
        for (int k = 0; k < TAPS; k++) chk($sformatf("sym_tap%0d", k), coef_out[k], g[k]);
`endif

        // asynchronous reset in the middle of a load
        rand_frame(f, 2);
        send_frame(f, 0, 0);
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < TAPS; k++) exp_bank[k] = '0;
        exp_ver = '0;
        chk_bank("midrst_bank");
        chk("midrst_ver", coef_version, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cfg_ready, 1);
        chk("midrst_upd", coef_updated, 0);
        chk("midrst_err", load_err, 0);
        rst = 1'b1;
        step();

        // 256 commits wrap the version counter
        for (int n = 0; n < 256; n++) begin
            rand_frame(f, N_LOAD);
            send_frame(f, 1, 0);
            tick_commit(f);
            if (n == 0) chk_bank("post_rst_bank");
            if (n == 254) chk("ver_255", coef_version, 255);
        end
        chk("ver_wrap", coef_version, 0);
        chk_bank("wrap_bank");
        step();
        chk("upd_count", upd_seen, exp_upd);
        chk("err_count", err_seen, exp_errp);

        repeat (120) begin
            int kind;
            kind = $urandom_range(0, 4);
            rand_frame(f, N_LOAD);
            case (kind)
                0: begin
                    send_frame(f, 1, 1);
                    repeat ($urandom_range(0, 3)) step();
                    chk("rnd_pending", busy, 1);
                    tick_commit(f);
                end
                1: begin
                    rand_frame(g, $urandom_range(1, N_LOAD - 1));
                    send_frame(g, 1, 1);
                    exp_errp++;
                end
                2: begin
                    send_frame(f, 0, 1);
                    exp_errp++;
                end
                3: begin
                    send_frame(f, 1, 1);
                    repeat ($urandom_range(0, 2)) step();
                    cfg_abort = 1'b1; sample_tick = 1'($urandom_range(0, 1));
                    step();
                    cfg_abort = 1'b0; sample_tick = 1'b0;
                end
                default: begin
                    rand_frame(g, $urandom_range(1, N_LOAD - 1));
                    send_frame(g, 0, 1);
                    cfg_valid = 1'b1; cfg_data = coef_t'($urandom); cfg_last = 1'($urandom_range(0, 1));
                    cfg_abort = 1'b1;
                    step();
                    cfg_valid = 1'b0; cfg_last = 1'b0; cfg_abort = 1'b0;
                end
            endcase
            step();
            step();
            chk($sformatf("rnd%0d_busy", kind), busy, 0);
            chk_bank($sformatf("rnd%0d_bank", kind));
            chk($sformatf("rnd%0d_ver", kind), coef_version, exp_ver);
            chk($sformatf("rnd%0d_upd", kind), upd_seen, exp_upd);
            chk($sformatf("rnd%0d_err", kind), err_seen, exp_errp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
